map_sc_scan: RTL and testbench
==============================

MAP_SC_SCAN -- requirements
Module: map_sc_scan

Interface
REQ-001 The block SHALL have parameter FFTSIZE, default 1024, number of subcarrier entries per bandwidth table.
REQ-002 The block SHALL have parameter NUM_BW, default 6, number of bandwidth tables.
REQ-003 The block SHALL have parameter CODE_W, default 2, width of one subcarrier map code.
REQ-004 The block SHALL have derived constants ADDR_W = clog2(FFTSIZE) and BW_W = max(1, clog2(NUM_BW)).
REQ-005 The block SHALL have port clk, input, 1, the single clock.
REQ-006 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-007 The block SHALL have port cfg_we, input, 1, table write strobe.
REQ-008 The block SHALL have port cfg_bw, input, BW_W, table select for the write.
REQ-009 The block SHALL have port cfg_addr, input, ADDR_W, subcarrier index for the write.
REQ-010 The block SHALL have port cfg_data, input, CODE_W, code to write.
REQ-011 The block SHALL have port start, input, 1, one-cycle request to scan one table.
REQ-012 The block SHALL have port bw_sel, input, BW_W, table to scan, sampled with start.
REQ-013 The block SHALL have port busy, output, 1, high while a scan is active.
REQ-014 The block SHALL have port rd_valid / rd_ready, output / input, 1 each, stream handshake.
REQ-015 The block SHALL have ports rd_code (output, CODE_W), rd_idx (output, ADDR_W) and rd_last (output, 1), which are the stream payload.
REQ-016 The block SHALL have ports n_active (output, ADDR_W+1) and done (output, 1): the count of non-NULL codes, and a one-cycle pulse when the scan ends.
REQ-017 The block SHALL have port err, output, 1, a one-cycle pulse when a request is rejected.

Function
REQ-018 Storage SHALL be NUM_BW*FFTSIZE entries of CODE_W bits, addressed {bw, idx}; writes SHALL take effect on the next clk edge.
REQ-019 A write with cfg_bw >= NUM_BW SHALL be dropped and SHALL pulse err.
REQ-020 A write while busy SHALL be dropped and SHALL pulse err; the table under scan never changes mid-scan.
REQ-021 The FSM SHALL have states IDLE, PRIME and STREAM, with transitions as follows:
- IDLE -> PRIME on start when bw_sel < NUM_BW.
- PRIME -> STREAM after the first read is issued.
- STREAM -> IDLE when the element with rd_last is accepted.
REQ-022 A start with bw_sel >= NUM_BW SHALL keep the FSM in IDLE and SHALL pulse err.
REQ-023 A start while busy SHALL be ignored, with no err pulse.
REQ-024 bw_sel SHALL be latched on the start cycle; later changes SHALL have no effect on the scan.
REQ-025 Indices SHALL be emitted 0..FFTSIZE-1 in order; rd_last SHALL be high only with idx FFTSIZE-1.
REQ-026 The first rd_valid SHALL assert exactly 2 cycles after start, given 1-cycle RAM read latency.
REQ-027 With rd_ready held high, one element SHALL transfer per cycle with no bubbles.
REQ-028 When rd_ready is low and rd_valid is high, rd_code, rd_idx and rd_last SHALL hold stable.
REQ-029 An element SHALL never be dropped or duplicated under any rd_ready pattern; a one-entry skid buffer absorbs the in-flight RAM read.
REQ-030 n_active SHALL count accepted elements whose rd_code != NULL; it SHALL clear at start and be final when done pulses.
REQ-031 done SHALL pulse on the cycle after the last element is accepted, with busy low on that same cycle.
REQ-032 busy SHALL be high from the cycle after an accepted start until the cycle done pulses.

Reset
REQ-033 On rst, the FSM SHALL enter IDLE, and rd_valid, busy, done, err, rd_last, rd_code, rd_idx, n_active and the skid buffer SHALL clear to 0.
REQ-034 Table contents SHALL NOT be cleared by rst.
REQ-035 rst asserted mid-scan SHALL abort the scan with outputs at reset values on the next cycle, and without a done pulse.
REQ-036 rst SHALL override start and cfg_we on the same cycle.

Structure
REQ-037 Package map_pkg SHALL hold the code type map_code_t (NULL=0, DATA=1, PILOT=2, GUARD=3 for CODE_W=2) and the FSM state enum.
REQ-038 The storage SHALL be one sub-module, sdp_ram: a simple dual-port RAM with one write port, one read port and registered read data of 1-cycle latency.

Verification
REQ-039 The bench SHALL cover table preload: load table 2 with idx mod 4 as the code, start with bw_sel=2, rd_ready=1 -> 1024 elements on consecutive cycles, code[k]=k mod 4, rd_last at k=1023, done 1 cycle later, n_active=768.
REQ-040 The bench SHALL cover backpressure: random rd_ready at 30 % -> the stream equals the preload in order, payload stable while stalled, no loss or duplicates.
REQ-041 The bench SHALL cover rejected requests: start with bw_sel=6 -> err pulse, busy stays 0; cfg_we during a scan -> err pulse, table unchanged on rescan.
REQ-042 The bench SHALL cover reset mid-scan: rst at element 500 -> rd_valid=0 and busy=0 next cycle, no done; a fresh start then scans from idx 0.
REQ-043 The bench SHALL cover latency and isolation: start -> first rd_valid exactly 2 cycles later; tables 0 and 5 are loaded with distinct patterns and each scan returns only its own table.

Source files
------------

// File: rtl/map_pkg.sv
// Shared types for the subcarrier map scanner.
//   map_code_t   : subcarrier map code stored per table entry
//   scan_state_t : scan controller states
package map_pkg;

   typedef enum logic [1:0] {
      NULL  = 2'd0,
      DATA  = 2'd1,
      PILOT = 2'd2,
      GUARD = 2'd3
   } map_code_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRIME  = 2'd1,
      STREAM = 2'd2
   } scan_state_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port, registered read data.
// Read data appears one clk after re/raddr and holds while re is low.
//   clk           : clock
//   we/waddr/wdata: write port, takes effect on the next clk edge
//   re/raddr      : read request
//   rdata         : registered read data
module sdp_ram #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int DW    = 2
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
      if (re) rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/map_sc_scan.sv
// Subcarrier map scanner: holds NUM_BW tables of FFTSIZE codes and streams
// one selected table out in index order over a valid/ready handshake,
// counting non-NULL codes.
//   clk, rst                       : clock, synchronous active-high reset
//   cfg_we/cfg_bw/cfg_addr/cfg_data: table write port (dropped while busy)
//   start/bw_sel                   : scan request and table select
//   busy                           : scan in progress
//   rd_valid/rd_ready              : stream handshake
//   rd_code/rd_idx/rd_last         : stream payload
//   n_active, done                 : non-NULL count, end-of-scan pulse
//   err                            : pulse for a rejected write or start
//
// state  | meaning
// IDLE   | waiting for start; table writes allowed
// PRIME  | first RAM read issued, data not yet out
// STREAM | elements flowing until the last one is accepted
module map_sc_scan
   import map_pkg::*;
#(
   parameter  int FFTSIZE = 1024,
   parameter  int NUM_BW  = 6,
   parameter  int CODE_W  = 2,
   localparam int ADDR_W  = $clog2(FFTSIZE),
   localparam int BW_W    = (NUM_BW > 1) ? $clog2(NUM_BW) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [BW_W-1:0]   cfg_bw,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [CODE_W-1:0] cfg_data,
   input  logic              start,
   input  logic [BW_W-1:0]   bw_sel,
   output logic              busy,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [CODE_W-1:0] rd_code,
   output logic [ADDR_W-1:0] rd_idx,
   output logic              rd_last,
   output logic [ADDR_W:0]   n_active,
   output logic              done,
   output logic              err
);

   localparam logic [BW_W:0]     NUM_BW_C = (BW_W+1)'(NUM_BW);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FFTSIZE-1);

   scan_state_t       state_q, state_d;
   logic [BW_W-1:0]   bw_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic              issued_all_q;
   // RAM output stage: valid flag and the index of the data it holds
   logic              ram_v_q;
   logic [ADDR_W-1:0] ram_idx_q;
   logic              ram_last_q;
   logic [CODE_W-1:0] ram_rdata;
   // skid entry catches the RAM word when the consumer stalls
   logic              skid_v_q;
   logic [CODE_W-1:0] skid_code_q;
   logic [ADDR_W-1:0] skid_idx_q;
   logic              skid_last_q;
   logic [ADDR_W:0]   n_active_q;
   logic              done_q, err_q;

   logic start_ok, wr_bad, start_bad, issue, accept, last_acc, ram_we;

   assign busy      = (state_q != IDLE);
   assign start_ok  = start && !busy && ({1'b0, bw_sel} < NUM_BW_C);
   assign start_bad = start && !busy && !({1'b0, bw_sel} < NUM_BW_C);
   assign wr_bad    = cfg_we && (busy || !({1'b0, cfg_bw} < NUM_BW_C));
   assign ram_we    = cfg_we && !wr_bad && !rst;

   // Reads stop while the skid is full, so at most one word is in flight
   // beyond the presented one; the RAM holds its output until re again.
   assign issue    = (state_q == PRIME) ||
                     ((state_q == STREAM) && !issued_all_q && !skid_v_q);
   assign rd_valid = skid_v_q | ram_v_q;
   assign accept   = rd_valid && rd_ready;
   assign last_acc = accept && rd_last;

   assign n_active = n_active_q;
   assign done     = done_q;
   assign err      = err_q;

   // Tables are addressed {bw, idx}; FFTSIZE is a power of two.
   sdp_ram #(
      .DEPTH (NUM_BW*FFTSIZE),
      .AW    (BW_W+ADDR_W),
      .DW    (CODE_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr ({cfg_bw, cfg_addr}),
      .wdata (cfg_data),
      .re    (issue),
      .raddr ({bw_q, rd_addr_q}),
      .rdata (ram_rdata)
   );

   always_comb begin
      rd_code = '0;
      rd_idx  = '0;
      rd_last = 1'b0;
      if (skid_v_q) begin
         rd_code = skid_code_q;
         rd_idx  = skid_idx_q;
         rd_last = skid_last_q;
      end else if (ram_v_q) begin
         rd_code = ram_rdata;
         rd_idx  = ram_idx_q;
         rd_last = ram_last_q;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_ok) state_d = PRIME;
         PRIME:   state_d = STREAM;
         STREAM:  if (last_acc) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         bw_q         <= '0;
         rd_addr_q    <= '0;
         issued_all_q <= 1'b0;
         ram_v_q      <= 1'b0;
         ram_idx_q    <= '0;
         ram_last_q   <= 1'b0;
         skid_v_q     <= 1'b0;
         skid_code_q  <= '0;
         skid_idx_q   <= '0;
         skid_last_q  <= 1'b0;
         n_active_q   <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= last_acc;
         err_q   <= wr_bad | start_bad;
         if (start_ok) begin
            bw_q         <= bw_sel;
            rd_addr_q    <= '0;
            issued_all_q <= 1'b0;
            ram_v_q      <= 1'b0;
            skid_v_q     <= 1'b0;
            n_active_q   <= '0;
         end else begin
            if (issue) begin
               rd_addr_q    <= rd_addr_q + ADDR_W'(1);
               issued_all_q <= (rd_addr_q == LAST_IDX);
               ram_idx_q    <= rd_addr_q;
               ram_last_q   <= (rd_addr_q == LAST_IDX);
            end
            // With the skid empty, the RAM word is either taken or parked.
            ram_v_q <= issue | (ram_v_q & skid_v_q);
            if (!skid_v_q) begin
               if (ram_v_q && !rd_ready) begin
                  skid_v_q    <= 1'b1;
                  skid_code_q <= ram_rdata;
                  skid_idx_q  <= ram_idx_q;
                  skid_last_q <= ram_last_q;
               end
            end else if (rd_ready) begin
               skid_v_q <= 1'b0;
            end
            if (accept && (rd_code != CODE_W'(NULL)))
               n_active_q <= n_active_q + (ADDR_W+1)'(1);
         end
      end
   end

endmodule

// File: tb/tb_map_sc_scan.sv
module tb_map_sc_scan;

   localparam int FFTSIZE = 1024;
   localparam int NUM_BW  = 6;
   localparam int CODE_W  = 2;
   localparam int ADDR_W  = 10;
   localparam int BW_W    = 3;

   logic              clk = 1'b0;
   logic              rst, cfg_we, start, rd_ready;
   logic [BW_W-1:0]   cfg_bw, bw_sel;
   logic [ADDR_W-1:0] cfg_addr;
   logic [CODE_W-1:0] cfg_data;
   logic              busy, rd_valid, rd_last, done, err;
   logic [CODE_W-1:0] rd_code;
   logic [ADDR_W-1:0] rd_idx;
   logic [ADDR_W:0]   n_active;

   int checks   = 0;
   int failures = 0;

   logic [CODE_W-1:0] model [NUM_BW][FFTSIZE];

   always #5 clk = ~clk;

   map_sc_scan #(.FFTSIZE(FFTSIZE), .NUM_BW(NUM_BW), .CODE_W(CODE_W)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_bw(cfg_bw), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .start(start), .bw_sel(bw_sel), .busy(busy),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_code(rd_code), .rd_idx(rd_idx),
      .rd_last(rd_last), .n_active(n_active), .done(done), .err(err)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   function automatic logic [CODE_W-1:0] pat(input int kind, input int idx);
      case (kind)
         0:       return CODE_W'(idx % 4);
         1:       return CODE_W'((idx >> 1) % 4);
         default: return CODE_W'(3 - (idx % 4));
      endcase
   endfunction

   task automatic load(input int bw, input int kind);
      int err_seen = 0;
      for (int i = 0; i < FFTSIZE; i++) begin
         @(negedge clk);
         if (err) err_seen++;
         cfg_we = 1'b1; cfg_bw = BW_W'(bw); cfg_addr = ADDR_W'(i); cfg_data = pat(kind, i);
         model[bw][i] = pat(kind, i);
      end
      @(negedge clk);
      if (err) err_seen++;
      cfg_we = 1'b0;
      check($sformatf("load%0d_err", bw), err_seen, 0);
   endtask

   task automatic scan(input int bw, input int pct, input bit chk_bubbles, output int got_n);
      int k = 0, cyc = 1, first_cyc = -1, exp_n = 0;
      int elem_err = 0, stall_err = 0, bubble_err = 0, busy_err = 0, early_done = 0;
      bit acc_last = 1'b0, pv = 1'b0, pready = 1'b0;
      logic [CODE_W-1:0] pc;
      logic [ADDR_W-1:0] pi;
      logic pl;
      string t;
      t = $sformatf("scan%0d_p%0d", bw, pct);
      for (int i = 0; i < FFTSIZE; i++) if (model[bw][i] != 0) exp_n++;
      @(negedge clk);
      start = 1'b1; bw_sel = BW_W'(bw);
      @(negedge clk);
      start = 1'b0; bw_sel = BW_W'((bw + 1) % NUM_BW);
      while (!acc_last && cyc < 20000) begin
         if (!busy) busy_err++;
         if (done) early_done++;
         if (rd_valid && first_cyc < 0) first_cyc = cyc;
         if (pv && !pready && (!rd_valid || rd_code !== pc || rd_idx !== pi || rd_last !== pl))
            stall_err++;
         if (chk_bubbles && first_cyc >= 0 && !rd_valid) bubble_err++;
         rd_ready = ($urandom_range(99) < pct);
         if (rd_valid && rd_ready) begin
            if (k >= FFTSIZE) elem_err++;
            else if (rd_idx !== ADDR_W'(k) || rd_code !== model[bw][k] ||
                     rd_last !== (k == FFTSIZE-1)) elem_err++;
            if (rd_last) acc_last = 1'b1;
            k++;
         end
         pv = rd_valid; pc = rd_code; pi = rd_idx; pl = rd_last; pready = rd_ready;
         if (!acc_last) begin
            @(negedge clk);
            cyc++;
         end
      end
      check({t, "_latency"}, first_cyc, 2);
      check({t, "_count"}, k, FFTSIZE);
      check({t, "_elems"}, elem_err, 0);
      check({t, "_stall"}, stall_err, 0);
      if (chk_bubbles) check({t, "_bubbles"}, bubble_err, 0);
      check({t, "_busy"}, busy_err, 0);
      check({t, "_early_done"}, early_done, 0);
      rd_ready = 1'b1;
      @(negedge clk);
      check({t, "_done"}, done, 1);
      check({t, "_busy_at_done"}, busy, 0);
      check({t, "_n_active"}, n_active, exp_n);
      got_n = int'(n_active);
      @(negedge clk);
      check({t, "_done_pulse"}, done, 0);
   endtask

   typedef struct {
      string           name;
      logic            start;
      logic [BW_W-1:0] bw_sel;
      logic            we;
      logic [BW_W-1:0] wbw;
      logic            exp_err;
      logic            exp_busy;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int n, found, done_seen;
      rst = 1'b1; cfg_we = 1'b0; cfg_bw = '0; cfg_addr = '0; cfg_data = '0;
      start = 1'b0; bw_sel = '0; rd_ready = 1'b0;

      vecs[0] = '{"start_bw6",   1'b1, 3'd6, 1'b0, 3'd0, 1'b1, 1'b0};
      vecs[1] = '{"start_bw7",   1'b1, 3'd7, 1'b0, 3'd0, 1'b1, 1'b0};
      vecs[2] = '{"wr_bw6",      1'b0, 3'd0, 1'b1, 3'd6, 1'b1, 1'b0};
      vecs[3] = '{"wr_bw7",      1'b0, 3'd0, 1'b1, 3'd7, 1'b1, 1'b0};
      vecs[4] = '{"wr_bw3_ok",   1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 1'b0};
      vecs[5] = '{"quiet",       1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0};
      vecs[6] = '{"start6_wr4",  1'b1, 3'd6, 1'b1, 3'd4, 1'b1, 1'b0};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_outputs", {busy, rd_valid, rd_last, done, err, rd_code, rd_idx, n_active}, 0);

      foreach (vecs[i]) begin
         @(negedge clk);
         start = vecs[i].start; bw_sel = vecs[i].bw_sel;
         cfg_we = vecs[i].we; cfg_bw = vecs[i].wbw; cfg_addr = ADDR_W'(7); cfg_data = 2'd1;
         @(negedge clk);
         start = 1'b0; cfg_we = 1'b0;
         check({vecs[i].name, "_err"}, err, vecs[i].exp_err);
         check({vecs[i].name, "_busy"}, busy, vecs[i].exp_busy);
         @(negedge clk);
         check({vecs[i].name, "_err_clear"}, err, 0);
         check({vecs[i].name, "_busy_later"}, busy, 0);
      end

      load(2, 0);
      load(0, 1);
      load(5, 2);

      scan(2, 100, 1'b1, n);
      check("preload_n_active_768", n, 768);
      scan(0, 100, 1'b1, n);
      scan(5, 100, 1'b1, n);
      scan(2, 30, 1'b0, n);
      check("bp_n_active_768", n, 768);

      // write and restart attempts during a scan
      @(negedge clk);
      start = 1'b1; bw_sel = 3'd2; rd_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      cfg_we = 1'b1; cfg_bw = 3'd2; cfg_addr = ADDR_W'(100); cfg_data = 2'd3;
      @(negedge clk);
      cfg_we = 1'b0;
      check("wr_busy_err", err, 1);
      start = 1'b1; bw_sel = 3'd0;
      @(negedge clk);
      start = 1'b0;
      check("start_busy_noerr", err, 0);
      check("start_busy_still_busy", busy, 1);
      found = 0;
      for (int c = 0; c < 3000 && found == 0; c++) begin
         @(negedge clk);
         if (done) found = 1;
      end
      check("busy_scan_done_seen", found, 1);
      check("busy_scan_busy_at_done", busy, 0);
      @(negedge clk);
      check("no_restart_after_done", {busy, rd_valid}, 0);
      scan(2, 100, 1'b1, n);

      // reset in the middle of a scan, overriding start and a write
      @(negedge clk);
      start = 1'b1; bw_sel = 3'd2; rd_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 0;
      for (int c = 0; c < 2000 && found == 0; c++) begin
         if (rd_valid && rd_idx == ADDR_W'(500)) found = 1;
         else @(negedge clk);
      end
      check("mid_rst_reached_500", found, 1);
      rst = 1'b1; start = 1'b1; bw_sel = 3'd5;
      cfg_we = 1'b1; cfg_bw = 3'd5; cfg_addr = ADDR_W'(0); cfg_data = ~model[5][0];
      @(negedge clk);
      rst = 1'b0; start = 1'b0; cfg_we = 1'b0;
      check("mid_rst_valid", rd_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_payload", {rd_idx, rd_code, rd_last, n_active}, 0);
      check("mid_rst_err", err, 0);
      done_seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      check("mid_rst_no_done", done_seen, 0);
      scan(5, 60, 1'b0, n);
      scan(2, 100, 1'b1, n);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
